// File: rtl/mem_sync_rw.sv
`default_nettype none
// ============================================================================
// Module      : mem_sync_rw
// Description : Clocked single-port RAM (DEPTH x DWIDTH) on a shared
//               bidirectional data bus with read/write strobes. Clears itself
//               after reset, acknowledges accesses with ready and latches
//               illegal requests on a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sync_rw #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [AWIDTH-1:0] addr,
  inout  wire  [DWIDTH-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Pointer and depth compare are one bit wider than the address so that
  // DEPTH == 2**AWIDTH is representable without wrapping.
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] LAST_W  = (AWIDTH+1)'(DEPTH - 1);

  logic [DWIDTH-1:0] mem [DEPTH];

  state_t            state;
  state_t            next_state;
  logic [AWIDTH:0]   ptr;
  logic [DWIDTH-1:0] rdata;

  logic              in_range;
  logic [DWIDTH-1:0] mem_rd;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              rdata_ld;
  logic              err_set;

  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign mem_rd   = in_range ? mem[addr] : '0;

  // Bus is driven only while a read is being served; dropping read releases
  // it combinationally in the same cycle.
  assign data = ((state == READ) && read) ? rdata : 'z;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus memory/read-data/error strobes.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data;
    rdata_ld   = 1'b0;
    err_set    = 1'b0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr[AWIDTH-1:0];
        mem_wdata = '0;
        if (ptr == LAST_W) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (read && write) begin
          err_set = 1'b1;
        end else if (write) begin
          if (in_range) begin
            mem_we     = 1'b1;
            next_state = WRITE;
          end else begin
            err_set = 1'b1;
          end
        end else if (read) begin
          rdata_ld   = 1'b1;
          next_state = READ;
          if (!in_range) begin
            err_set = 1'b1;
          end
        end
      end
      READ: begin
        // Reload every cycle so address changes during a held read show up
        // one cycle later.
        rdata_ld = 1'b1;
        if (!read) begin
          next_state = IDLE;
        end
      end
      WRITE: begin
        if (!write) begin
          next_state = IDLE;
        end
      end
      default: next_state = INIT;
    endcase
  end

  // Registered outputs, clear pointer and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      ready <= 1'b0;
      busy  <= 1'b1;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      if (state == INIT) begin
        ptr <= ptr + 1'b1;
      end
      ready <= (next_state == READ) || (next_state == WRITE);
      busy  <= (next_state == INIT);
      if (err_set) begin
        err <= 1'b1;
      end
      if (rdata_ld) begin
        rdata <= mem_rd;
      end
    end
  end

  // Storage array; a reset edge never writes.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_sync_rw.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sync_rw
// Description : Scoreboard bench for mem_sync_rw; two instances (DEPTH 32
//               and DEPTH 20) driven against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sync_rw;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rd [2];
  logic       wr [2];
  logic       oe [2];
  logic [4:0] ad [2];
  logic [7:0] drv [2];
  logic       ready_s [2];
  logic       busy_s [2];
  logic       err_s [2];
  wire  [7:0] bus0;
  wire  [7:0] bus1;

  assign bus0 = oe[0] ? drv[0] : 'z;
  assign bus1 = oe[1] ? drv[1] : 'z;

  mem_sync_rw dut0 (
    .clk(clk), .rst(rst), .read(rd[0]), .write(wr[0]), .addr(ad[0]),
    .data(bus0), .ready(ready_s[0]), .busy(busy_s[0]), .err(err_s[0])
  );

  mem_sync_rw #(.DWIDTH(8), .AWIDTH(5), .DEPTH(20)) dut1 (
    .clk(clk), .rst(rst), .read(rd[1]), .write(wr[1]), .addr(ad[1]),
    .data(bus1), .ready(ready_s[1]), .busy(busy_s[1]), .err(err_s[1])
  );

  // Reference model: plain arrays plus sticky error flags.
  int         depth [2] = '{32, 20};
  logic [7:0] mm [2][32];
  logic       err_m [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] e0, e1;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: every acknowledged read cycle pops one expected word.
  always @(negedge clk) begin
    if (ready_s[0] && rd[0]) begin
      n_chk++;
      if (exp_q0.size() == 0) begin
        n_fail++;
        $display("FAIL rdata0: unexpected read ack, got %h expected none", bus0);
      end else begin
        e0 = exp_q0.pop_front();
        if (bus0 !== e0) begin
          n_fail++;
          $display("FAIL rdata0: got %h expected %h", bus0, e0);
        end
      end
    end
    if (ready_s[1] && rd[1]) begin
      n_chk++;
      if (exp_q1.size() == 0) begin
        n_fail++;
        $display("FAIL rdata1: unexpected read ack, got %h expected none", bus1);
      end else begin
        e1 = exp_q1.pop_front();
        if (bus1 !== e1) begin
          n_fail++;
          $display("FAIL rdata1: got %h expected %h", bus1, e1);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      err_m[u] = 1'b0;
      for (int a = 0; a < 32; a++) mm[u][a] = 8'h00;
    end
  endtask

  task automatic do_read(input int u, input int a);
    logic [7:0] ev;
    ev = (a < depth[u]) ? mm[u][a] : 8'h00;
    if (a >= depth[u]) err_m[u] = 1'b1;
    if (u == 0) exp_q0.push_back(ev); else exp_q1.push_back(ev);
    rd[u] = 1'b1;
    ad[u] = 5'(a);
    cyc();
    chk("read_ready", int'(ready_s[u]), 1);
    cyc();
    rd[u] = 1'b0;
    cyc();
    chk("read_release_ready", int'(ready_s[u]), 0);
    chk("read_err", int'(err_s[u]), int'(err_m[u]));
  endtask

  task automatic do_write(input int u, input int a, input logic [7:0] v, input int hold);
    bit inr;
    inr = (a < depth[u]);
    if (inr) mm[u][a] = v; else err_m[u] = 1'b1;
    wr[u]  = 1'b1;
    ad[u]  = 5'(a);
    oe[u]  = 1'b1;
    drv[u] = v;
    cyc();
    drv[u] = ~v;
    chk("write_ready", int'(ready_s[u]), int'(inr));
    repeat (hold) cyc();
    wr[u] = 1'b0;
    oe[u] = 1'b0;
    cyc();
    chk("write_release_ready", int'(ready_s[u]), 0);
    chk("write_err", int'(err_s[u]), int'(err_m[u]));
  endtask

  task automatic do_both(input int u, input int a);
    err_m[u] = 1'b1;
    rd[u] = 1'b1;
    wr[u] = 1'b1;
    ad[u] = 5'(a);
    cyc();
    chk("both_ready", int'(ready_s[u]), 0);
    chk("both_err", int'(err_s[u]), 1);
    rd[u] = 1'b0;
    wr[u] = 1'b0;
    cyc();
    chk("both_ready_after", int'(ready_s[u]), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    for (int u = 0; u < 2; u++) begin
      chk("rst_ready", int'(ready_s[u]), 0);
      chk("rst_busy", int'(busy_s[u]), 1);
      chk("rst_err", int'(err_s[u]), 0);
    end
    cyc();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic wait_init();
    int c0 = 0;
    int c1 = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy_s[0]) c0++;
      if (busy_s[1]) c1++;
      if (!busy_s[0] && !busy_s[1]) break;
      cyc();
    end
    chk("init_cycles0", c0, 32);
    chk("init_cycles1", c1, 20);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; oe[u] = 1'b0; ad[u] = '0; drv[u] = '0;
    end
    model_clear();
    do_reset();
    wait_init();

    // Cleared contents on both instances.
    for (int a = 0; a < 32; a++) do_read(0, a);
    for (int a = 0; a < 20; a++) do_read(1, a);

    // Write identity pattern and read it back.
    for (int a = 0; a < 32; a++) do_write(0, a, 8'(a), 0);
    for (int a = 0; a < 32; a++) do_read(0, a);

    // Held write: bus changes after accept, first value must stick.
    do_write(0, 3, 8'hA5, 4);
    do_read(0, 3);

    // Out-of-range and boundary on the DEPTH=20 instance.
    do_write(1, 25, 8'hFF, 0);
    do_read(1, 25);
    do_write(1, 19, 8'h3C, 1);
    do_read(1, 19);

    // Simultaneous strobes: error, no access, sticky.
    do_both(0, 10);
    do_read(0, 10);
    do_write(0, 11, 8'h77, 0);
    do_read(0, 11);

    // Reset during a held read of addr 7.
    exp_q0.push_back(mm[0][7]);
    rd[0] = 1'b1;
    ad[0] = 5'd7;
    cyc();
    chk("held_read_ready", int'(ready_s[0]), 1);
    do_reset();
    rd[0] = 1'b0;
    wait_init();
    do_read(0, 7);

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int u, op, a;
      u  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 19));
      a  = int'($urandom_range(0, 31));
      if (op < 9)       do_write(u, a, 8'($urandom), int'($urandom_range(0, 3)));
      else if (op < 19) do_read(u, a);
      else              do_both(u, a);
    end

    cyc();
    chk("queue0_drained", exp_q0.size(), 0);
    chk("queue1_drained", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_sync_rw.md
# mem_sync_rw

Parametrised, clocked successor to the 32x8 asynchronous memory: a single-port RAM of DEPTH words by DWIDTH bits on a shared bidirectional data bus with read/write strobes. It self-clears after reset, acknowledges every access with `ready`, and flags illegal requests on a sticky `err`. It sits between the CPU bus controller and the storage array.

## Interface
- `DWIDTH`, 8, data word width in bits
- `AWIDTH`, 5, address width in bits
- `DEPTH`, 32, number of implemented words; must satisfy 1 <= DEPTH <= 2**AWIDTH
- `clk`  input  1  clock; all state changes on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `read`  input  1  read request (level)
- `write`  input  1  write request (level)
- `addr`  input  AWIDTH  word address
- `data`  inout  DWIDTH  shared data bus; driven by the block only while a read is being served, otherwise high-Z
- `ready`  output  1  access acknowledge
- `busy`  output  1  initialisation in progress
- `err`  output  1  sticky illegal-request flag

## Operation
- States: INIT, IDLE, READ, WRITE.
- Reset (rst=1 at a rising edge): state INIT, clear pointer=0, `busy`=1, `ready`=0, `err`=0, `data` high-Z. Reset wins over any request and aborts any access in progress; no memory write occurs on a reset edge.
- INIT: each cycle writes 0 to mem[pointer] and increments the pointer; after writing word DEPTH-1, go to IDLE with `busy`=0. INIT takes exactly DEPTH cycles. `read`/`write` are ignored in INIT: not queued, and `err` is not set.
- IDLE, sampled at a rising edge:
  - `write`=1, `read`=0, addr<DEPTH: mem[addr] <= `data` on that edge; go to WRITE.
  - `read`=1, `write`=0, addr<DEPTH: rdata <= mem[addr]; go to READ.
  - `read`=1 and `write`=1: `err` <= 1; no access; stay in IDLE.
  - Either strobe with addr>=DEPTH: `err` <= 1. A write is dropped; a read enters READ with rdata <= 0.
- WRITE: `ready`=1. Exactly one memory write per request; holding `write` high does not rewrite. Return to IDLE at the first edge with `write`=0.
- READ: `ready`=1. `data` = rdata when `read`=1; output enable = (state==READ) & `read`, combinational in `read`, so the bus is released in the same cycle that `read` drops. rdata reloads every cycle from mem[addr], or from 0 if addr>=DEPTH, so address changes during a held read appear one cycle later. Return to IDLE at the first edge with `read`=0.
- `err` clears only on reset.
- Widths: the pointer is AWIDTH+1 bits so DEPTH=2**AWIDTH terminates without wrap ambiguity. `addr` is compared to DEPTH unsigned.

## Timing
- All outputs are registered except `data` enable (see READ).
- Reset values: `ready`=0, `busy`=1, `err`=0, `data`=Z.
- Write latency: memory updated at the accepting edge; `ready` high from the next cycle until one cycle after `write` falls.
- Read latency: 1 cycle. Request sampled at edge N; `data` valid and `ready`=1 from edge N+1.
- Minimum access is 2 cycles: accept, then acknowledge with strobe low.
- First access is possible at the edge DEPTH+1 cycles after reset deasserts.

## Test plan
- Reset, then count cycles while `busy`=1 -> exactly 32 cycles (defaults); then read all 32 addresses -> every word 8'h00, `data`=Z between reads.
- Write mem[i]=i for i=0..31, then read i=0..31 -> `data`==i with `ready`=1 one cycle after each request; bus Z whenever `read`=0; `err`=0 throughout.
- Hold `write`=1 for 5 cycles at addr 3 while changing the bus from 8'hA5 to 8'h5A after the accepting edge -> mem[3] reads 8'hA5.
- Assert `read`=1 and `write`=1 together in IDLE -> `err`=1, no `ready`, memory unchanged; `err` stays 1 until `rst`.
- With DEPTH=20, AWIDTH=5: write 8'hFF to addr 25 -> `err`=1; a read of addr 25 returns 8'h00; writing and reading addr 19 works normally.
- Assert `rst` during a held read of addr 7 -> `data` goes Z and `ready`=0 after the edge, `busy`=1, and after INIT mem[7] reads 8'h00.
